// File: rtl/line_crop.sv
// line_crop: forwards a per-frame shadowed rectangular window of padded lines.
// Optional macro LINE_CROP_LINE_CHECK_EN enables the short/long line pulse.
module line_crop #(
  parameter logic [11:0] H_DISP = 12'd1920,
  parameter logic [11:0] V_DISP = 12'd1080,
  parameter int          DW     = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync_i,
  input  logic [DW-1:0] data_i,
  input  logic          dataValid_i,
  input  logic [11:0]   cfg_x_start,
  input  logic [11:0]   cfg_width,
  input  logic [11:0]   cfg_y_start,
  input  logic [11:0]   cfg_height,
  output logic [DW-1:0] data_o,
  output logic          dataValid_o,
  output logic          line_err_o
);

  typedef enum logic [1:0] {
    WAIT_FRAME,
    BLANK,
    IN_LINE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [11:0]   r_px;
  logic [11:0]   r_line;
  logic [11:0]   r_xs;
  logic [11:0]   r_w;
  logic [11:0]   r_ys;
  logic [11:0]   r_h;
  logic [DW-1:0] r_data;
  logic          r_valid;

  logic [12:0] w_xsum;
  logic [12:0] w_ysum;
  logic [12:0] w_xend;
  logic [12:0] w_yend;
  logic        w_in_x;
  logic        w_in_y;
  logic        w_keep;
  logic        w_line_end;

  // 13-bit window ends so start+size never wraps before clamping
  assign w_xsum = {1'b0, r_xs} + {1'b0, r_w};
  assign w_ysum = {1'b0, r_ys} + {1'b0, r_h};
  assign w_xend = (w_xsum > {1'b0, H_DISP}) ? {1'b0, H_DISP} : w_xsum;
  assign w_yend = (w_ysum > {1'b0, V_DISP}) ? {1'b0, V_DISP} : w_ysum;

  assign w_in_x = ({1'b0, r_px} >= {1'b0, r_xs})
                & ({1'b0, r_px} < w_xend);
  assign w_in_y = ({1'b0, r_line} >= {1'b0, r_ys})
                & ({1'b0, r_line} < w_yend);

  assign w_keep = dataValid_i & (r_state != WAIT_FRAME)
                & ~vsync_i & w_in_x & w_in_y;

  assign w_line_end = (r_state == IN_LINE) & ~dataValid_i & ~vsync_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_FRAME;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      WAIT_FRAME: if (vsync_i) w_state_nxt = BLANK;
      BLANK: begin
        if (vsync_i)          w_state_nxt = BLANK;
        else if (dataValid_i) w_state_nxt = IN_LINE;
      end
      IN_LINE: begin
        if (vsync_i)           w_state_nxt = BLANK;
        else if (!dataValid_i) w_state_nxt = BLANK;
      end
      default: w_state_nxt = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_px   <= '0;
      r_line <= '0;
      r_xs   <= '0;
      r_w    <= '0;
      r_ys   <= '0;
      r_h    <= '0;
    end else if (vsync_i) begin
      r_px   <= '0;
      r_line <= '0;
      r_xs   <= cfg_x_start;
      r_w    <= cfg_width;
      r_ys   <= cfg_y_start;
      r_h    <= cfg_height;
    end else if (r_state != WAIT_FRAME) begin
      if (dataValid_i) begin
        if (r_px != 12'hFFF) r_px <= r_px + 12'd1;
      end else if (r_state == IN_LINE) begin
        r_px <= '0;
        if (r_line != 12'hFFF) r_line <= r_line + 12'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= w_keep;
      r_data  <= w_keep ? data_i : '0;
    end
  end

  assign dataValid_o = r_valid;
  assign data_o      = r_data;

`ifdef LINE_CROP_LINE_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_line_end & (r_px != H_DISP);
  end

  assign line_err_o = r_err;
`else
  assign line_err_o = 1'b0;
  logic w_unused;
  assign w_unused = w_line_end;
`endif

endmodule

// File: tb/tb_line_crop.sv
// tb_line_crop: random and directed stimulus against a per-pixel window model.
// Literal pixel counts pin the model for the directed scenarios.
module tb_line_crop;

  localparam int H = 1920;
  localparam int V = 1080;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vsync_i = 1'b0;
  logic [23:0] data_i = '0;
  logic        dataValid_i = 1'b0;
  logic [11:0] cfg_x_start = '0;
  logic [11:0] cfg_width = '0;
  logic [11:0] cfg_y_start = '0;
  logic [11:0] cfg_height = '0;
  logic [23:0] data_o;
  logic        dataValid_o;
  logic        line_err_o;

  line_crop dut (
    .clk         (clk),
    .rst         (rst),
    .vsync_i     (vsync_i),
    .data_i      (data_i),
    .dataValid_i (dataValid_i),
    .cfg_x_start (cfg_x_start),
    .cfg_width   (cfg_width),
    .cfg_y_start (cfg_y_start),
    .cfg_height  (cfg_height),
    .data_o      (data_o),
    .dataValid_o (dataValid_o),
    .line_err_o  (line_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // frame-level model: window from cfg captured at the frame pulse
  int framed = 0, inln = 0, px = 0, ln = 0;
  int sxs = 0, sw = 0, sys = 0, sh = 0;
  int pend_v = 0, pend_d = 0, pend_e = 0;
  int cur_v = 0, cur_d = 0, cur_e = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input bit vs, input bit dv, input int d);
    pend_v = 0;
    pend_d = 0;
    pend_e = 0;
    if (vs) begin
      framed = 1;
      sxs = cfg_x_start; sw = cfg_width;
      sys = cfg_y_start; sh = cfg_height;
      px = 0; ln = 0; inln = 0;
    end else if (framed != 0) begin
      if (dv) begin
        if (px >= sxs && px < imin(sxs + sw, H) &&
            ln >= sys && ln < imin(sys + sh, V)) begin
          pend_v = 1;
          pend_d = d;
        end
        px = imin(px + 1, 4095);
        inln = 1;
      end else if (inln != 0) begin
`ifdef LINE_CROP_LINE_CHECK_EN
        pend_e = (px != H) ? 1 : 0;
`endif
        ln = imin(ln + 1, 4095);
        px = 0;
        inln = 0;
      end
    end
  endtask

  int outq[$];
  int n_err = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("dataValid_o", int'(dataValid_o), cur_v);
      chk("data_o", int'(data_o), cur_d);
      chk("line_err_o", int'(line_err_o), cur_e);
      if (dataValid_o) outq.push_back(int'(data_o));
      if (line_err_o) n_err++;
      if (rst) begin
        cur_v = 0; cur_d = 0; cur_e = 0;
      end else begin
        cur_v = pend_v; cur_d = pend_d; cur_e = pend_e;
      end
    end
  end

  task automatic cyc(input bit vs, input bit dv, input int d);
    @(posedge clk);
    #1;
    vsync_i = vs;
    dataValid_i = dv;
    data_i = 24'(d);
    model_step(vs, dv, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic line(input int len);
    for (int i = 0; i < len; i++) cyc(0, 1, i);
    cyc(0, 0, 0);
  endtask

  task automatic frame(input int xs, input int w, input int ys, input int h);
    cfg_x_start = 12'(xs); cfg_width = 12'(w);
    cfg_y_start = 12'(ys); cfg_height = 12'(h);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
  endtask

  int b, e0;
  int err_exp;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    b = outq.size();
    line(H);
    idle(3);
    chk("noframe_cnt", outq.size() - b, 0);

    b = outq.size(); e0 = n_err;
    frame(100, 200, 1, 2);
    for (int l = 0; l < 4; l++) line(H);
    idle(3);
    chk("basic_cnt", outq.size() - b, 400);
    chk("basic_first", outq[b], 100);
    chk("basic_last", outq[$], 299);
    chk("basic_lerr", n_err - e0, 0);

    b = outq.size();
    frame(1900, 100, 0, 1);
    line(H);
    idle(3);
    chk("clamp_cnt", outq.size() - b, 20);
    chk("clamp_first", outq[b], 1900);
    chk("clamp_last", outq[$], 1919);

    b = outq.size();
    frame(0, 0, 0, 5);
    line(H);
    idle(3);
    chk("width0_cnt", outq.size() - b, 0);

    frame(100, 200, 0, 3);
    line(H);
    cfg_x_start = 12'd500;
    b = outq.size();
    line(H);
    line(H);
    idle(3);
    chk("shadow_cnt", outq.size() - b, 400);
    chk("shadow_first", outq[b], 100);
    b = outq.size();
    frame(500, 200, 0, 1);
    line(H);
    idle(3);
    chk("next_first", outq[b], 500);
    chk("next_cnt", outq.size() - b, 200);

    b = outq.size(); e0 = n_err;
    frame(100, 200, 0, 1);
    for (int i = 0; i < 150; i++) cyc(0, 1, i);
    cyc(1, 1, 150);
    cyc(0, 0, 0);
    line(H);
    idle(3);
    chk("abort_cnt", outq.size() - b, 250);
    chk("abort_lerr", n_err - e0, 0);

`ifdef LINE_CROP_LINE_CHECK_EN
    err_exp = 1;
`else
    err_exp = 0;
`endif
    e0 = n_err;
    frame(0, 10, 0, 10);
    line(1000);
    line(H);
    idle(3);
    chk("short_lerr", n_err - e0, err_exp);

    b = outq.size();
    frame(0, 1, 1075, 100);
    for (int l = 0; l < 1090; l++) line(2);
    idle(3);
    chk("vclamp_cnt", outq.size() - b, 5);

    for (int f = 0; f < 20; f++) begin
      frame($urandom_range(0, 30), $urandom_range(0, 30),
            $urandom_range(0, 6), $urandom_range(0, 6));
      for (int l = 0; l < $urandom_range(3, 10); l++) begin
        int len;
        len = $urandom_range(1, 40);
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 299) == 0)
            cyc(1, 1'($urandom_range(0, 1)), int'($urandom & 32'hFF_FFFF));
          else
            cyc(0, 1, int'($urandom & 32'hFF_FFFF));
          if ($urandom_range(0, 99) == 0)
            cfg_x_start = 12'($urandom_range(0, 30));
        end
        idle($urandom_range(1, 3));
      end
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
